tile_writer: RTL and testbench

TILE_WRITER -- requirements
Module: tile_writer

---
 rtl/tile_writer_if.sv | 23 ++
 rtl/tile_writer.sv | 152 +++++++++++++++
 tb/tb_tile_writer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/tile_writer_if.sv
// Request and memory-write channels of the tile writer.
// master: request source / memory port side; slave: the tile writer itself.
interface tile_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_col;
  logic [6:0]  req_row;
  logic [15:0] req_glyph;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_grant;

  modport master (
    output req_valid, req_col, req_row, req_glyph, mem_grant,
    input  req_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  req_valid, req_col, req_row, req_glyph, mem_grant,
    output req_ready, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/tile_writer.sv
// Buffers tile draw requests and writes glyph codes into the tile map in shared
// memory; also sweeps the whole map with a clear glyph on request.
module tile_writer #(
  parameter logic [15:0] BASE_ADDR   = 16'd40000,
  parameter int unsigned COLS        = 160,
  parameter int unsigned ROWS        = 120,
  parameter logic [15:0] CLEAR_GLYPH = 16'd0,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  tile_writer_if.slave bus,
  input  logic         clear_start,
  output logic         busy,
  output logic         clear_done,
  output logic         req_err
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [14:0] LAST_TILE = 15'(COLS * ROWS - 1);

  typedef struct packed {
    logic [7:0]  col;
    logic [6:0]  row;
    logic [15:0] glyph;
  } tileReq_t;

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  state_t           state, stateNext;
  tileReq_t         fifoMem [FIFO_DEPTH];
  tileReq_t         head;
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] fifoCount;
  logic             fifoFull, fifoEmpty;
  logic             accept, inRange, push, pop;
  logic             clearPending, clearPendingNext;
  logic [14:0]      clearCnt, clearCntNext;
  logic [15:0]      memAddrNext, memWdataNext, headAddr;
  logic             memWeNext, clearDoneNext;

  assign fifoFull  = (fifoCount == CNT_W'(FIFO_DEPTH));
  assign fifoEmpty = (fifoCount == '0);
  assign head      = fifoMem[rdPtr];
  assign headAddr  = BASE_ADDR + 16'(head.row) * 16'(COLS) + 16'(head.col);

  // Readiness uses only registered state, so a pop cannot open a slot the same cycle.
  assign bus.req_ready = !fifoFull && (state != CLEAR) && !clearPending;
  assign accept        = bus.req_valid && bus.req_ready;
  assign inRange       = (32'(bus.req_col) < COLS) && (32'(bus.req_row) < ROWS);
  assign push          = accept && inRange;
  assign busy          = !fifoEmpty || (state != IDLE) || clearPending;

  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= '{col: bus.req_col, row: bus.req_row, glyph: bus.req_glyph};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      fifoCount <= fifoCount + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Next state and next values of the registered memory-port outputs.
  always_comb begin
    stateNext        = state;
    pop              = 1'b0;
    clearPendingNext = clearPending;
    clearCntNext     = clearCnt;
    memAddrNext      = bus.mem_addr;
    memWdataNext     = bus.mem_wdata;
    memWeNext        = bus.mem_we;
    clearDoneNext    = 1'b0;

    if (clear_start && (state != CLEAR)) clearPendingNext = 1'b1;

    unique case (state)
      IDLE: begin
        if (clearPending) begin
          stateNext    = CLEAR;
          clearCntNext = '0;
          memAddrNext  = BASE_ADDR;
          memWdataNext = CLEAR_GLYPH;
          memWeNext    = 1'b1;
        end else if (!fifoEmpty) begin
          pop          = 1'b1;
          memAddrNext  = headAddr;
          memWdataNext = head.glyph;
          memWeNext    = 1'b1;
          stateNext    = WRITE;
        end
      end
      WRITE: begin
        if (bus.mem_grant) begin
          if (!fifoEmpty && !clearPending) begin
            pop          = 1'b1;
            memAddrNext  = headAddr;
            memWdataNext = head.glyph;
          end else begin
            memWeNext = 1'b0;
            stateNext = IDLE;
          end
        end
      end
      CLEAR: begin
        if (bus.mem_grant) begin
          if (clearCnt == LAST_TILE) begin
            memWeNext        = 1'b0;
            clearDoneNext    = 1'b1;
            clearPendingNext = 1'b0;
            clearCntNext     = '0;
            stateNext        = IDLE;
          end else begin
            clearCntNext = clearCnt + 15'd1;
            memAddrNext  = BASE_ADDR + 16'(clearCnt + 15'd1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      clearPending  <= 1'b0;
      clearCnt      <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      clear_done    <= 1'b0;
      req_err       <= 1'b0;
    end else begin
      state         <= stateNext;
      clearPending  <= clearPendingNext;
      clearCnt      <= clearCntNext;
      bus.mem_addr  <= memAddrNext;
      bus.mem_wdata <= memWdataNext;
      bus.mem_we    <= memWeNext;
      clear_done    <= clearDoneNext;
      req_err       <= accept && !inRange;
    end
  end

endmodule

// File: tb/tb_tile_writer.sv
// Directed bench for tile_writer: vector table of single requests plus
// sequences for latency, back-pressure, clear preemption and reset mid-clear.
module tb_tile_writer;
  logic clk = 1'b0;
  logic reset_n;
  logic clear_start;
  logic busy, clear_done, req_err;

  tile_writer_if bus ();

  tile_writer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .clear_start (clear_start),
    .busy        (busy),
    .clear_done  (clear_done),
    .req_err     (req_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observed write stream {addr, data} and event counters, written only here.
  logic [31:0] wrQ [$];
  int accCount = 0, errCount = 0, doneCount = 0, doneAtWrites = 0;
  always @(posedge clk) begin
    if (bus.mem_we && bus.mem_grant) wrQ.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.req_valid && bus.req_ready) accCount++;
    if (req_err) errCount++;
    if (clear_done) begin
      doneCount++;
      doneAtWrites = wrQ.size();
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendReq(input logic [7:0] c, input logic [6:0] r, input logic [15:0] g);
    bus.req_col   = c;
    bus.req_row   = r;
    bus.req_glyph = g;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  col;
    logic [6:0]  row;
    logic [15:0] glyph;
    bit          expErr;
    logic [15:0] expAddr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int wb, ab, eb, db, n, bad;

    vecs[0] = '{8'd5,   7'd2,   16'd4,      1'b0, 16'd40325};
    vecs[1] = '{8'd0,   7'd0,   16'hABCD,   1'b0, 16'd40000};
    vecs[2] = '{8'd159, 7'd119, 16'h1234,   1'b0, 16'd59199};
    vecs[3] = '{8'd160, 7'd0,   16'd7,      1'b1, 16'd0};
    vecs[4] = '{8'd0,   7'd120, 16'd7,      1'b1, 16'd0};
    vecs[5] = '{8'd255, 7'd127, 16'd1,      1'b1, 16'd0};
    vecs[6] = '{8'd100, 7'd60,  16'hFFFF,   1'b0, 16'd49700};

    reset_n       = 1'b0;
    clear_start   = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_col   = '0;
    bus.req_row   = '0;
    bus.req_glyph = '0;
    bus.mem_grant = 1'b1;
    #3;
    check("reset mem_we",     32'(bus.mem_we),    32'd0);
    check("reset busy",       32'(busy),          32'd0);
    check("reset req_ready",  32'(bus.req_ready), 32'd1);
    check("reset mem_addr",   32'(bus.mem_addr),  32'd0);
    check("reset mem_wdata",  32'(bus.mem_wdata), 32'd0);
    check("reset clear_done", 32'(clear_done),    32'd0);
    check("reset req_err",    32'(req_err),       32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    tick();

    // Latency: accepted at edge N, mem_we seen after edge N+1, one write only.
    wb = wrQ.size();
    sendReq(8'd5, 7'd2, 16'd4);
    check("lat mem_we after N",    32'(bus.mem_we),   32'd0);
    tick();
    check("lat mem_we after N+1",  32'(bus.mem_we),   32'd1);
    check("lat mem_addr",          32'(bus.mem_addr), 32'd40325);
    check("lat mem_wdata",         32'(bus.mem_wdata), 32'd4);
    repeat (3) tick();
    check("lat write count",       32'(wrQ.size() - wb), 32'd1);
    check("lat busy idle",         32'(busy), 32'd0);

    // Table of single requests with grant tied high.
    for (int i = 0; i < 7; i++) begin
      wb = wrQ.size();
      ab = accCount;
      eb = errCount;
      sendReq(vecs[i].col, vecs[i].row, vecs[i].glyph);
      repeat (4) tick();
      check($sformatf("vec%0d accepted", i), 32'(accCount - ab), 32'd1);
      check($sformatf("vec%0d req_err", i), 32'(errCount - eb), 32'(vecs[i].expErr));
      check($sformatf("vec%0d writes", i), 32'(wrQ.size() - wb), vecs[i].expErr ? 32'd0 : 32'd1);
      if (!vecs[i].expErr && wrQ.size() > wb)
        check($sformatf("vec%0d write", i), wrQ[wb], {vecs[i].expAddr, vecs[i].glyph});
      check($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
    end

    // Back-pressure: one write held in flight, then six offered, four queued.
    bus.mem_grant = 1'b0;
    wb = wrQ.size();
    sendReq(8'd1, 7'd0, 16'h00A0);
    tick();
    check("bp inflight mem_we", 32'(bus.mem_we), 32'd1);
    ab = accCount;
    for (int i = 0; i < 6; i++) begin
      bus.req_col   = 8'(10 + i);
      bus.req_row   = 7'd3;
      bus.req_glyph = 16'(16'h0100 + i);
      bus.req_valid = 1'b1;
      tick();
    end
    bus.req_valid = 1'b0;
    check("bp accepted",        32'(accCount - ab), 32'd4);
    check("bp req_ready full",  32'(bus.req_ready), 32'd0);
    check("bp addr held",       32'(bus.mem_addr),  32'd40001);
    check("bp busy",            32'(busy),          32'd1);
    bus.mem_grant = 1'b1;
    #1;
    check("bp ready during pop", 32'(bus.req_ready), 32'd0);
    tick();
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    check("bp drain timeout", 32'(busy), 32'd0);
    check("bp write count", 32'(wrQ.size() - wb), 32'd5);
    if (wrQ.size() >= wb + 5) begin
      check("bp write A", wrQ[wb], {16'd40001, 16'h00A0});
      for (int i = 0; i < 4; i++)
        check($sformatf("bp write %0d", i), wrQ[wb + 1 + i],
              {16'(40000 + 480 + 10 + i), 16'(16'h0100 + i)});
    end
    check("bp ready after", 32'(bus.req_ready), 32'd1);

    // Clear preempts queued entries but waits for the in-flight write.
    bus.mem_grant = 1'b0;
    wb = wrQ.size();
    db = doneCount;
    sendReq(8'd2, 7'd1, 16'd9);
    sendReq(8'd3, 7'd1, 16'd10);
    sendReq(8'd4, 7'd1, 16'd11);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("clr ready pending", 32'(bus.req_ready), 32'd0);
    check("clr busy pending",  32'(busy), 32'd1);
    bus.mem_grant = 1'b1;
    n = 0;
    while ((doneCount == db || busy) && n < 25000) begin tick(); n++; end
    check("clr timeout", 32'((doneCount == db) || busy), 32'd0);
    check("clr done pulses", 32'(doneCount - db), 32'd1);
    check("clr write count", 32'(wrQ.size() - wb), 32'd19203);
    check("clr done position", 32'(doneAtWrites - wb), 32'd19201);
    if (wrQ.size() >= wb + 19203) begin
      check("clr inflight write", wrQ[wb], {16'd40162, 16'd9});
      bad = 0;
      for (int k = 0; k < 19200; k++)
        if (wrQ[wb + 1 + k] !== {16'(40000 + k), 16'd0}) bad++;
      check("clr sweep bad writes", 32'(bad), 32'd0);
      check("clr queued write 1", wrQ[wb + 19201], {16'd40163, 16'd10});
      check("clr queued write 2", wrQ[wb + 19202], {16'd40164, 16'd11});
    end

    // Reset in the middle of a clear sweep.
    db = doneCount;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (!(bus.mem_we && bus.mem_addr == 16'd40100) && n < 500) begin tick(); n++; end
    check("rst reach count 100", 32'(bus.mem_addr), 32'd40100);
    reset_n = 1'b0;
    #1;
    check("rst mem_we async", 32'(bus.mem_we),   32'd0);
    check("rst mem_addr",     32'(bus.mem_addr), 32'd0);
    repeat (2) tick();
    @(negedge clk);
    reset_n = 1'b1;
    check("rst busy after",  32'(busy), 32'd0);
    check("rst ready after", 32'(bus.req_ready), 32'd1);
    wb = wrQ.size();
    ab = accCount;
    bus.req_col   = 8'd7;
    bus.req_row   = 7'd7;
    bus.req_glyph = 16'h0077;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("rst first edge accept", 32'(accCount - ab), 32'd1);
    repeat (4) tick();
    check("rst no clear_done", 32'(doneCount - db), 32'd0);
    check("rst write count", 32'(wrQ.size() - wb), 32'd1);
    if (wrQ.size() > wb)
      check("rst write", wrQ[wb], {16'd41127, 16'h0077});
    check("rst busy idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
